// File: rtl/lc3b_pkg.sv
// lc3b_pkg: shared definitions for the LC-3b memory-access path.
//   - state_e   : memory-access FSM states
//   - RW_*      : R_W encodings (read / write)
//   - SIZE_*    : DATA_SIZE encodings (byte / word)
package lc3b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge bus between the memory-access
// unit (master) and a variable-latency memory (slave).
//   mem_req   : request, held until acknowledged or timed out
//   mem_we    : write strobe, valid while mem_req
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables, one per byte lane
//   mem_wdata : write data
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : access accepted / read data valid
interface mem_access_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mdr_format.sv
// mdr_format: combinational MDR formatting.
//   mdr       in  : raw MDR contents
//   lane      in  : byte lane selected by the low MAR bits
//   data_size in  : 1 = word, 0 = byte
//   bus_byte  in  : low byte of the datapath bus
//   mdr_out   out : MDR for words, sign-extended selected byte for bytes
//   bus_repl  out : bus_byte replicated into every lane (byte MDR load)
module mdr_format
  import lc3b_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]           mdr,
  input  logic [$clog2(DATA_W/8)-1:0] lane,
  input  logic                        data_size,
  input  logic [7:0]                  bus_byte,
  output logic [DATA_W-1:0]           mdr_out,
  output logic [DATA_W-1:0]           bus_repl
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = mdr[7:0];
    for (int i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) sel_byte = mdr[i*8 +: 8];
    end
  end

  assign mdr_out  = (data_size == SIZE_WORD) ? mdr
                                             : {{(DATA_W-8){sel_byte[7]}}, sel_byte};
  assign bus_repl = {LANES{bus_byte}};

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR memory-access unit for the LC-3b datapath.
// Owns MAR and MDR and runs a req/ack handshake to a variable-latency
// memory, returning the one-cycle R pulse to the microsequencer.
//   clk, rst              : clock, asynchronous active-low reset
//   LD_MAR, LD_MDR        : register load enables
//   MIO_EN, R_W, DATA_SIZE: access request, direction (1=write), size (1=word)
//   BUS_IN                : datapath bus
//   MAR, MDR, MDR_OUT     : address register, raw data register, GateMDR value
//   R, UNALIGNED, MEM_ERR : completion pulse and its error causes
//   mem                   : memory bus (master side)
module mem_access_unit
  import lc3b_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LD_MAR,
  input  logic               LD_MDR,
  input  logic               MIO_EN,
  input  logic               R_W,
  input  logic               DATA_SIZE,
  input  logic [DATA_W-1:0]  BUS_IN,
  output logic [ADDR_W-1:0]  MAR,
  output logic [DATA_W-1:0]  MDR,
  output logic [DATA_W-1:0]  MDR_OUT,
  output logic               R,
  output logic               UNALIGNED,
  output logic               MEM_ERR,
  mem_access_unit_if.master  mem
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_req_q, mem_we_q;
  logic [LANES-1:0]    mem_be_q, be_sel;
  logic                unal_q, merr_q;
  logic                go_req, go_unal, go_tout;
  logic [LANE_W-1:0]   lane;
  logic [ADDR_W-1:0]   mar_load;
  logic [DATA_W-1:0]   bus_repl;

  assign lane = MAR[LANE_W-1:0];

  generate
    if (ADDR_W > DATA_W) begin : g_mar_zext
      assign mar_load = {{(ADDR_W-DATA_W){1'b0}}, BUS_IN};
    end else begin : g_mar_trunc
      assign mar_load = BUS_IN[ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    be_sel = '0;
    if (DATA_SIZE == SIZE_WORD) begin
      be_sel = '1;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane == LANE_W'(i)) be_sel[i] = 1'b1;
      end
    end
  end

  // Next-state logic. A misaligned word access fails straight from IDLE so
  // the memory never sees it; in REQ an ack beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    go_req  = 1'b0;
    go_unal = 1'b0;
    go_tout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MIO_EN) begin
          if (DATA_SIZE == SIZE_WORD && lane != '0) begin
            state_d = ST_ERR;
            go_unal = 1'b1;
          end else begin
            state_d = ST_REQ;
            go_req  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_ERR;
          go_tout = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers. cnt_q holds the number of the current REQ cycle
  // (1 in the first), so ERR follows exactly TIMEOUT unacknowledged cycles.
  // The cause flags are written every edge and are therefore only ever set
  // during the single ERR cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_be_q  <= '0;
      unal_q    <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unal_q  <= go_unal;
      merr_q  <= go_tout;
      if (go_req) begin
        mem_req_q <= 1'b1;
        mem_we_q  <= (R_W == RW_WRITE);
        mem_be_q  <= be_sel;
        cnt_q     <= CNT_W'(1);
      end else if (state_q == ST_REQ && state_d != ST_REQ) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        mem_be_q  <= '0;
        cnt_q     <= '0;
      end else if (state_q == ST_REQ) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // MAR and MDR are frozen while a request is outstanding so the memory sees
  // a stable address and write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MAR <= '0;
      MDR <= '0;
    end else begin
      if (LD_MAR && state_q != ST_REQ) MAR <= mar_load;
      if (state_q == ST_REQ) begin
        if (mem.mem_ack && LD_MDR && mem_we_q == RW_READ) MDR <= mem.mem_rdata;
      end else if (!MIO_EN && LD_MDR) begin
        MDR <= (DATA_SIZE == SIZE_BYTE) ? bus_repl : BUS_IN;
      end
    end
  end

  mdr_format #(.DATA_W(DATA_W)) u_mdr_format (
    .mdr       (MDR),
    .lane      (lane),
    .data_size (DATA_SIZE),
    .bus_byte  (BUS_IN[7:0]),
    .mdr_out   (MDR_OUT),
    .bus_repl  (bus_repl)
  );

  assign R         = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign UNALIGNED = unal_q;
  assign MEM_ERR   = merr_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_addr  = {MAR[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
  assign mem.mem_wdata = MDR;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit (16-bit,
// TIMEOUT=4). The bench plays the memory and keeps its own expected MAR/MDR.
module tb_mem_access_unit;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ld_mar, ld_mdr, mio_en, r_w, data_size;
  logic [DW-1:0] bus_in;
  logic [AW-1:0] mar;
  logic [DW-1:0] mdr, mdr_out;
  logic          r, unal, merr;

  mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .LD_MAR    (ld_mar),
    .LD_MDR    (ld_mdr),
    .MIO_EN    (mio_en),
    .R_W       (r_w),
    .DATA_SIZE (data_size),
    .BUS_IN    (bus_in),
    .MAR       (mar),
    .MDR       (mdr),
    .MDR_OUT   (mdr_out),
    .R         (r),
    .UNALIGNED (unal),
    .MEM_ERR   (merr),
    .mem       (mif.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mdr;

  // GateMDR value from the rules: word -> raw, byte -> sign-extended byte at MAR[0].
  function automatic logic [15:0] exp_out(input logic [15:0] v, input logic [15:0] a,
                                          input logic sz);
    logic [7:0] b;
    int s;
    b = 8'((v >> (8 * int'(a[0]))) & 16'h00FF);
    s = $signed(b);
    return sz ? v : 16'(s);
  endfunction

  task automatic set_mar(input logic [15:0] a);
    ld_mar = 1'b1; bus_in = a;
    @(negedge clk);
    ld_mar = 1'b0;
    m_mar  = a;
    n_checks++;
    if (mar !== m_mar) begin
      n_fail++; $display("FAIL mar_load got=%h want=%h", mar, m_mar);
    end
  endtask

  task automatic load_mdr(input logic [15:0] v, input logic sz);
    ld_mdr = 1'b1; data_size = sz; bus_in = v; mio_en = 1'b0;
    @(negedge clk);
    ld_mdr = 1'b0;
    m_mdr  = sz ? v : {v[7:0], v[7:0]};
    n_checks++;
    if (mdr !== m_mdr) begin
      n_fail++; $display("FAIL mdr_load got=%h want=%h", mdr, m_mdr);
    end
  endtask

  // One access; waits >= TO means the memory never acknowledges.
  task automatic access(input logic rw, input logic sz, input int waits,
                        input logic [15:0] rdata, input logic ld);
    logic        unal_exp, tout;
    logic [1:0]  be_exp;
    logic [35:0] got, want;
    unal_exp = sz && m_mar[0];
    tout     = (waits >= TO);
    be_exp   = sz ? 2'b11 : (m_mar[0] ? 2'b10 : 2'b01);
    mio_en = 1'b1; r_w = rw; data_size = sz; ld_mdr = ld;
    @(negedge clk);
    mio_en = 1'b0;
    if (unal_exp) begin
      ld_mdr = 1'b0;
      n_checks++;
      if ({r, unal, merr, mif.mem_req} !== 4'b1100) begin
        n_fail++; $display("FAIL unaligned_flags got=%b want=1100", {r, unal, merr, mif.mem_req});
      end
    end else begin
      for (int c = 0; c < TO; c++) begin
        got  = {r, mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata};
        want = {1'b0, 1'b1, rw, be_exp, m_mar & 16'hFFFE, m_mdr};
        n_checks++;
        if (got !== want) begin
          n_fail++; $display("FAIL req_bus cycle=%0d got=%h want=%h", c, got, want);
        end
        // LD_MAR during REQ must be ignored.
        ld_mar = 1'($urandom); bus_in = 16'($urandom);
        if (!tout && c == waits) begin
          mif.mem_ack = 1'b1; mif.mem_rdata = rdata;
        end
        @(negedge clk);
        ld_mar = 1'b0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 16'($urandom);
        if (!tout && c == waits) break;
      end
      ld_mdr = 1'b0;
      if (!tout && !rw && ld) m_mdr = rdata;
      n_checks++;
      if ({r, unal, merr} !== {1'b1, 1'b0, tout}) begin
        n_fail++; $display("FAIL done_flags got=%b want=%b", {r, unal, merr}, {1'b1, 1'b0, tout});
      end
    end
    n_checks++;
    if ({mar, mdr, mdr_out} !== {m_mar, m_mdr, exp_out(m_mdr, m_mar, sz)}) begin
      n_fail++; $display("FAIL mdr_value got=%h/%h/%h want=%h/%h/%h", mar, mdr, mdr_out,
                         m_mar, m_mdr, exp_out(m_mdr, m_mar, sz));
    end
    @(negedge clk);
    n_checks++;
    if ({r, unal, merr, mif.mem_req} !== 4'b0000) begin
      n_fail++; $display("FAIL pulse_end got=%b want=0000", {r, unal, merr, mif.mem_req});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; data_size = 0; bus_in = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mar, mdr, r, unal, merr, mif.mem_req, mif.mem_we, mif.mem_be} !== 39'd0) begin
      n_fail++; $display("FAIL reset_state got=%h/%h/%b want=0", mar, mdr,
                         {r, unal, merr, mif.mem_req, mif.mem_we, mif.mem_be});
    end
    rst = 1'b1;
    m_mar = '0; m_mdr = '0;
    @(negedge clk);
    // Reset in the middle of an outstanding request.
    set_mar(16'h5002);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b0;
    @(negedge clk);
    mio_en = 1'b0;
    n_checks++;
    if (mif.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_req_start got=%b want=1", mif.mem_req);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mif.mem_req, r, mar} !== 18'd0) begin
      n_fail++; $display("FAIL async_reset got=%b/%b/%h want=0/0/0000", mif.mem_req, r, mar);
    end
    @(negedge clk);
    rst = 1'b1;
    m_mar = '0; m_mdr = '0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'hBEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({r, mif.mem_req, mdr} !== {2'b00, 16'h0000}) begin
        n_fail++; $display("FAIL late_ack_after_reset got=%b/%b/%h want=0/0/0000", r, mif.mem_req, mdr);
      end
    end
    mif.mem_ack = 1'b0;
  endtask

  task automatic test_directed();
    set_mar(16'h3000);
    access(1'b0, 1'b1, 3, 16'h8001, 1'b1);
    n_checks++;
    if (mdr !== 16'h8001) begin
      n_fail++; $display("FAIL word_read_mdr got=%h want=8001", mdr);
    end
    set_mar(16'h3001);
    access(1'b0, 1'b0, 0, 16'h80FF, 1'b1);
    n_checks++;
    if (mdr_out !== 16'hFF80) begin
      n_fail++; $display("FAIL byte_read_sext got=%h want=ff80", mdr_out);
    end
    load_mdr(16'h1234, 1'b0);
    n_checks++;
    if (mdr !== 16'h3434) begin
      n_fail++; $display("FAIL byte_replicate got=%h want=3434", mdr);
    end
    set_mar(16'h4000);
    access(1'b1, 1'b0, 1, 16'h0000, 1'b0);
    set_mar(16'h4001);
    access(1'b0, 1'b1, 0, 16'h0000, 1'b1);
  endtask

  task automatic test_timeout();
    load_mdr(16'hA5C3, 1'b1);
    set_mar(16'h4000);
    access(1'b0, 1'b1, TO, 16'h0000, 1'b1);
    n_checks++;
    if (mdr !== 16'hA5C3) begin
      n_fail++; $display("FAIL timeout_mdr got=%h want=a5c3", mdr);
    end
    mif.mem_ack = 1'b1;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    n_checks++;
    if ({r, mif.mem_req} !== 2'b00) begin
      n_fail++; $display("FAIL late_ack_ignored got=%b want=00", {r, mif.mem_req});
    end
  endtask

  // MIO_EN and mem_ack held high: one access every three cycles (REQ, DONE, IDLE).
  task automatic test_back_to_back();
    set_mar(16'h2000);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; mif.mem_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if ({mif.mem_req, r} !== {c % 3 == 0, c % 3 == 1}) begin
        n_fail++; $display("FAIL back_to_back cycle=%0d got=%b want=%b", c, {mif.mem_req, r},
                           {c % 3 == 0, c % 3 == 1});
      end
      if (c == 5) begin
        mio_en = 1'b0; mif.mem_ack = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) load_mdr(16'($urandom), 1'($urandom));
      set_mar(16'($urandom));
      access(1'($urandom), 1'($urandom), int'($urandom_range(0, 5)), 16'($urandom),
             1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Parametrised MAR/MDR memory-access unit for the LC-3b datapath.
- Owns MAR and MDR and runs a request/acknowledge handshake to a memory with variable latency.
- Supports byte and word accesses, a configurable data width and an access timeout, and returns the `R` ready signal to the microsequencer.
- Replaces the fixed 16-bit MAR/MDR/memory path inside the datapath.

## Interface

Parameters:
- DATA_W, 16, datapath/memory word width; multiple of 8, ≥16.
- ADDR_W, 16, byte-address width.
- TIMEOUT, 255, maximum cycles in REQ without `mem_ack` before an error; ≥1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- LD_MAR  in  1  load MAR from BUS_IN.
- LD_MDR  in  1  load MDR: from memory during a read, from BUS_IN otherwise.
- MIO_EN  in  1  request a memory access.
- R_W  in  1  1 = write, 0 = read.
- DATA_SIZE  in  1  1 = word, 0 = byte.
- BUS_IN  in  DATA_W  datapath bus.
- MAR  out  ADDR_W  address register.
- MDR  out  DATA_W  raw data register.
- MDR_OUT  out  DATA_W  value driven onto the bus under GateMDR: MDR for word accesses, sign-extended selected byte for byte accesses.
- R  out  1  one-cycle access-complete pulse.
- UNALIGNED  out  1  one-cycle pulse, coincident with R, when a word access was misaligned.
- MEM_ERR  out  1  one-cycle pulse, coincident with R, when the access timed out.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write strobe, valid while mem_req.
- mem_addr  out  ADDR_W  word-aligned address: MAR with low log2(DATA_W/8) bits zeroed.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  equals MDR.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mem_ack  in  1  access accepted or data valid.

## Operation

- LANES = DATA_W/8.
- lane = MAR[log2(LANES)-1:0].
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - MIO_EN=1 with DATA_SIZE=1 and lane≠0 → ERR with the UNALIGNED cause.
  - MIO_EN=1 otherwise → REQ; mem_req, mem_we (=R_W) and mem_be are registered on the entry edge.
- REQ:
  - mem_req held high; address, be, we and wdata held stable.
  - mem_ack=1 → DONE.
  - Cycle counter reaches TIMEOUT → ERR with the MEM_ERR cause.
- DONE: R=1 for one cycle; then IDLE.
- ERR: R=1 plus the cause pulse for one cycle; then IDLE. No memory request is issued for an unaligned access.
- mem_be:
  - Word access: all ones.
  - Byte access: one-hot at lane.
- MAR:
  - Loads BUS_IN[ADDR_W-1:0] when LD_MAR=1, zero-extended if ADDR_W>DATA_W.
  - LD_MAR is ignored in REQ.
- MDR:
  - Outside an access (MIO_EN=0) with LD_MDR=1: word size loads BUS_IN; byte size loads BUS_IN[7:0] replicated into every lane.
  - Read: loads mem_rdata on the edge where mem_ack=1 in REQ, if LD_MDR=1.
  - Otherwise MDR holds.
- MDR_OUT: DATA_SIZE ? MDR : sign-extend(MDR byte at lane). Combinational.
- mem_ack outside REQ (late ack after a timeout or reset) is ignored.

## Timing

- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - MAR, MDR and the timeout counter clear to 0.
  - R, UNALIGNED, MEM_ERR, mem_req, mem_we and mem_be clear to 0 immediately.
  - Reset mid-access drops mem_req without waiting for an ack.
- Latency:
  - MIO_EN sampled at edge t0; mem_req is high from t0.
  - Zero-wait memory (ack in the first REQ cycle): R is high in the cycle after t0+1, i.e. a minimum of 2 cycles from the sample edge to the R edge.
  - Each wait cycle adds 1.
- Unaligned access: R and UNALIGNED are high in the cycle after t0.
- Timeout: ERR is entered after exactly TIMEOUT REQ cycles without an ack.
- Back-to-back accesses: MIO_EN still high in the DONE cycle is not sampled; the next access starts from IDLE one cycle later.
- Simultaneous mem_ack and counter==TIMEOUT: ack wins, giving DONE.

## Structure

- The shared package `lc3b_pkg` holds:
  - the state enum (IDLE/REQ/DONE/ERR);
  - RW_READ/RW_WRITE and SIZE_BYTE/SIZE_WORD constants.
- One combinational sub-module `mdr_format` provides lane select, sign extension and byte replication, parametrised by DATA_W.
- The FSM, counter and registers stay in `mem_access_unit`.

## Test plan

- Reset mid-REQ (rst low for 1 cycle) → mem_req, R and MAR all 0 at once; a later mem_ack produces no R.
- Word read at MAR=0x3000, ack after 3 wait cycles, mem_rdata=0x8001, LD_MDR=1 → mem_be=2'b11, R one cycle, MDR=0x8001.
- Byte read at MAR=0x3001, mem_rdata=0x80FF → mem_be=2'b10, MDR_OUT=0xFF80.
- Byte write: BUS_IN=0x1234 with LD_MDR, then write at MAR=0x4000 → mem_wdata=0x3434, mem_be=2'b01, mem_we=1.
- Word access at MAR=0x4001 → no mem_req; R and UNALIGNED high in the cycle after the sample edge.
- TIMEOUT=4 with no ack → R and MEM_ERR after 4 REQ cycles, MDR unchanged.
